// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_e;

    localparam int unsigned CausePll = 0;
    localparam int unsigned CauseExt = 1;
    localparam int unsigned CauseSw  = 2;

endpackage

// File: rtl/rst_seq_debounce.sv
// Debounces a synchronised active-low reset. The fault flag clears only after
// Cycles consecutive high samples.
module rst_seq_debounce #(
    parameter int unsigned Cycles = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic flt_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);
    localparam logic [CntW-1:0] CntSat = CntW'(Cycles);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flt_q, flt_d;

    always_comb begin
        cnt_d = cnt_q;
        flt_d = flt_q;
        if (!in_i) begin
            cnt_d = '0;
            flt_d = 1'b1;
        end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CntSat) flt_d = 1'b0;
        end
    end

    // The board reset reads as a fault out of reset until it has been seen stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            flt_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            flt_q <= flt_d;
        end
    end

    assign flt_o = flt_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronises PLL lock and board reset, holds all domains in
// reset, then releases the active-low reset outputs one by one.
//
// state   | meaning
// ASSERT  | all outputs in reset, waiting for fault to clear
// HOLD    | counting fault-free cycles before the first release
// RELEASE | releasing rst_no[k] every GapCycles cycles
// RUN     | all resets released, cause register frozen
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned NumRst         = 3,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned HoldCycles     = 16,
    parameter int unsigned GapCycles      = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pll_locked_i,
    input  logic              ext_rst_ni,
    input  logic              sw_rst_req_i,
    output logic [NumRst-1:0] rst_no,
    output logic [2:0]        rst_cause_o,
    output logic              busy_o
);

    localparam int unsigned IdxW   = (NumRst > 1) ? $clog2(NumRst) : 1;
    localparam int unsigned TmrMax = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [TmrW-1:0] HoldLoad = TmrW'(HoldCycles - 1);
    localparam logic [TmrW-1:0] GapLoad  = TmrW'(GapCycles - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumRst - 1);

    logic [SyncStages-1:0] pll_sync_q, ext_sync_q;
    logic                  pll_s, ext_s, ext_flt, fault;
    logic [2:0]            cause_cur;

    rst_seq_state_e    state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NumRst-1:0] rst_q, rst_d;
    logic [2:0]        cause_q, cause_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pll_sync_q <= '0;
            ext_sync_q <= '0;
        end else begin
            pll_sync_q <= {pll_sync_q[SyncStages-2:0], pll_locked_i};
            ext_sync_q <= {ext_sync_q[SyncStages-2:0], ext_rst_ni};
        end
    end

    assign pll_s = pll_sync_q[SyncStages-1];
    assign ext_s = ext_sync_q[SyncStages-1];

    rst_seq_debounce #(
        .Cycles (DebounceCycles)
    ) u_ext_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (ext_s),
        .flt_o  (ext_flt)
    );

    always_comb begin
        cause_cur           = '0;
        cause_cur[CausePll] = !pll_s;
        cause_cur[CauseExt] = ext_flt;
        cause_cur[CauseSw]  = sw_rst_req_i;
    end

    assign fault = |cause_cur;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cause_d = cause_q;
        if (fault) begin
            state_d = ASSERT;
            rst_d   = '0;
            // A fresh fault after a clean run replaces the history; otherwise accumulate.
            cause_d = (state_q == RUN) ? cause_cur : (cause_q | cause_cur);
        end else begin
            case (state_q)
                ASSERT: begin
                    state_d = HOLD;
                    tmr_d   = HoldLoad;
                end
                HOLD: begin
                    if (tmr_q == '0) begin
                        rst_d   = rst_q | NumRst'(1);
                        idx_d   = IdxW'(1);
                        tmr_d   = GapLoad;
                        state_d = (NumRst == 1) ? RUN : RELEASE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (tmr_q == '0) begin
                        rst_d = rst_q | (NumRst'(1) << idx_q);
                        tmr_d = GapLoad;
                        if (idx_q == LastIdx) state_d = RUN;
                        else                  idx_d   = idx_q + 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ASSERT;
            tmr_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            cause_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
        end
    end

    assign rst_no      = rst_q;
    assign rst_cause_o = cause_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with NumRst=3, SyncStages=2, DebounceCycles=3,
// HoldCycles=4, GapCycles=2.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll = 1'b1;
    logic       ext = 1'b1;
    logic       sw = 1'b0;
    logic [2:0] rst_no;
    logic [2:0] cause;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .NumRst         (3),
        .SyncStages     (2),
        .DebounceCycles (3),
        .HoldCycles     (4),
        .GapCycles      (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pll_locked_i (pll),
        .ext_rst_ni   (ext),
        .sw_rst_req_i (sw),
        .rst_no       (rst_no),
        .rst_cause_o  (cause),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rst_ni released just after an edge: sync 2 edges, debounce 3 more, then +5/+7/+9.
    task automatic power_up();
        logic [2:0] exp;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp = (e < 10) ? 3'b000 : (e < 12) ? 3'b001 : (e < 14) ? 3'b011 : 3'b111;
            chk("pwr_rst", {29'd0, rst_no}, {29'd0, exp});
            if (e == 13 || e == 14) chk("pwr_busy", {31'd0, busy}, {31'd0, (e == 13)});
        end
        chk("pwr_cause", {29'd0, cause}, 32'd3);
    endtask

    // Called right after the edge that forced rst_no to 0 with the fault gone next cycle.
    task automatic seq_after_fault(input string tag);
        logic [2:0] exp;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = (i < 5) ? 3'b000 : (i < 7) ? 3'b001 : (i < 9) ? 3'b011 : 3'b111;
            chk(tag, {29'd0, rst_no}, {29'd0, exp});
        end
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rst", {29'd0, rst_no}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_cause", {29'd0, cause}, 32'd0);

        // 1. power-up
        rst_n = 1'b1;
        power_up();

        // 2. single-cycle PLL loss in RUN
        pll = 1'b0;
        tick();
        pll = 1'b1;
        tick();
        chk("pll_early", {29'd0, rst_no}, 32'd7);
        tick();
        chk("pll_rst", {29'd0, rst_no}, 32'd0);
        chk("pll_busy", {31'd0, busy}, 32'd1);
        chk("pll_cause", {29'd0, cause}, 32'd1);
        seq_after_fault("pll_seq");
        chk("pll_cause_run", {29'd0, cause}, 32'd1);

        // 3. bouncing board reset
        ext = 1'b0;
        tick(); tick(); tick();
        chk("ext_early", {29'd0, rst_no}, 32'd7);
        tick();
        chk("ext_rst", {29'd0, rst_no}, 32'd0);
        chk("ext_cause", {29'd0, cause}, 32'd2);
        ext = 1'b1; tick();
        ext = 1'b0; tick();
        ext = 1'b1; tick(); tick();
        ext = 1'b0; tick();
        ext = 1'b1; tick();
        ext = 1'b0; tick(); tick();
        chk("ext_bounce", {29'd0, rst_no}, 32'd0);
        ext = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("ext_rel", {29'd0, rst_no}, (i < 10) ? 32'd0 : 32'd1);
        end
        chk("ext_cause2", {29'd0, cause}, 32'd2);

        // 4. software reset mid-RELEASE
        tick();
        chk("sw_pre", {29'd0, rst_no}, 32'd1);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("sw_rst", {29'd0, rst_no}, 32'd0);
        chk("sw_cause", {29'd0, cause}, 32'd6);
        seq_after_fault("sw_seq");
        chk("sw_cause_run", {29'd0, cause}, 32'd6);

        // 5. asynchronous sequencer reset in RUN
        rst_n = 1'b0;
        #1;
        chk("arst_rst", {29'd0, rst_no}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        chk("arst_cause", {29'd0, cause}, 32'd0);
        tick();
        rst_n = 1'b1;
        power_up();

        // 6. PLL loss and sw request reaching the FSM on the same edge
        pll = 1'b0;
        tick();
        pll = 1'b1;
        tick();
        chk("both_early", {29'd0, rst_no}, 32'd7);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("both_rst", {29'd0, rst_no}, 32'd0);
        chk("both_cause", {29'd0, cause}, 32'd5);
        seq_after_fault("both_seq");
        chk("both_cause_run", {29'd0, cause}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
